// File: rtl/mux4_rr_select.sv
// Round-robin arbiter producing the registered 2-bit select and one-hot grant
// for a MUX4. Each grant is bounded to BURST cycles so no requester starves.
module mux4_rr_select #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [1:0] S,
  output logic [3:0] grant,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [3:0] BURST_C  = 4'(BURST);

  // Returns {found, index} of the first requester after 'last', wrapping mod 4.
  // Scanning from the lowest priority upwards lets the nearest hit win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [0:0] state_q, state_d;
  logic [1:0] last_q,  last_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [1:0] s_q,     s_d;
  logic [3:0] grant_q, grant_d;
  logic       busy_q,  busy_d;

  logic       rel_s;
  logic [1:0] arb_last_s;
  logic [2:0] pick_s;

  // Release decision and arbitration base; a releasing channel becomes 'last'
  // before the same-edge re-arbitration.
  always_comb begin
    rel_s      = 1'b0;
    arb_last_s = last_q;
    if (state_q == ST_GRANT) begin
      rel_s      = ~req[s_q] | (cnt_q == BURST_C);
      arb_last_s = s_q;
    end else begin
      rel_s      = 1'b0;
      arb_last_s = last_q;
    end
    pick_s = rr_pick(req, arb_last_s);
  end

  // Next-state logic for the IDLE/GRANT machine and its registered outputs.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[2]) begin
          state_d = ST_GRANT;
          s_d     = pick_s[1:0];
          grant_d = 4'b0001 << pick_s[1:0];
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
        end else begin
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
        end
      end
      ST_GRANT: begin
        if (rel_s) begin
          last_d = s_q;
          if (pick_s[2]) begin
            state_d = ST_GRANT;
            s_d     = pick_s[1:0];
            grant_d = 4'b0001 << pick_s[1:0];
            busy_d  = 1'b1;
            cnt_d   = 4'd1;
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        last_d  = 2'd3;
        cnt_d   = 4'd0;
        s_d     = 2'b00;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
      s_q     <= 2'b00;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign S     = s_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux4_rr_select.sv
// Self-checking bench for mux4_rr_select: directed scenarios plus sticky random
// requests, compared each cycle against an integer-level round-robin model.
module tb_mux4_rr_select;

  localparam int BURST = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [1:0] S;
  logic [3:0] grant;
  logic       busy;

  mux4_rr_select #(.BURST(BURST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .S       (S),
    .grant   (grant),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: owner (-1 when nobody holds the grant), cycles held,
  // last released channel, and the select value shown on S.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 3;
  int m_sel   = 0;

  logic [7:0] mux_data [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after.
  task automatic step(input logic [3:0] r, input logic rn);
    bit hunt;
    logic [7:0] y;
    req     = r;
    reset_n = rn;
    for (int i = 0; i < 4; i++) mux_data[i] = 8'($urandom_range(0, 255));
    @(posedge clk);
    if (!rn) begin
      m_owner = -1; m_held = 0; m_last = 3; m_sel = 0;
    end else begin
      hunt = (m_owner < 0);
      if (m_owner >= 0 && (r[m_owner] == 1'b0 || m_held == BURST)) begin
        m_last  = m_owner;
        m_owner = -1;
        hunt    = 1'b1;
      end
      if (hunt) begin
        for (int k = 1; k <= 4 && m_owner < 0; k++) begin
          if (r[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
            m_held  = 1;
            m_sel   = m_owner;
          end
        end
      end else begin
        m_held++;
      end
    end
    #1;
    check("S", 32'(S), 32'(m_sel));
    check("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
    if (m_owner >= 0) begin
      y = mux_data[S];
      check("mux_y", 32'(y), 32'(mux_data[m_owner]));
    end
  endtask

  logic [3:0] rnd_req;

  initial begin
    req     = 4'b0000;
    reset_n = 1'b0;

    // Reset and idle
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    repeat (3) step(4'b0000, 1'b1);

    // Single request dropped early: grant persists one tail cycle, S holds
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("s_hold_after_drop", 32'(S), 32'd2);

    // Burst rotation from reset: four grants of BURST cycles each, no gap
    step(4'b0000, 1'b0);
    repeat (16) step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // Sole requester regains grant at burst expiry with no deassert cycle
    repeat (10) begin
      step(4'b0010, 1'b1);
      check("sole_grant", 32'(grant), 32'd2);
    end
    step(4'b0000, 1'b1);

    // Wrap-around: after channel 3 releases, channel 0 wins over 3
    step(4'b0000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b1001, 1'b1);
    check("wrap_sel", 32'(S), 32'd0);

    // Reset mid-grant, then re-grant on the next edge
    step(4'b0000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b0);
    check("rst_mid_grant", 32'(grant), 32'd0);
    step(4'b1000, 1'b1);
    check("regrant_after_rst", 32'(grant), 32'd8);

    // Random sticky requests with occasional resets
    rnd_req = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) rnd_req[b] = ~rnd_req[b];
      end
      step(rnd_req, ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
